// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Single-port 32-bit data memory behind a valid/ready request channel and a
// valid/ready response channel, with a fixed number of wait states per access.
//
// Optional build macro: DMEM_BYTE_EN_EN
//   defined   -> ReqByteEn port present, stores write only the enabled bytes
//   undefined -> no ReqByteEn port, every store writes the full word
//
// Parameters
//   ADDR_WIDTH  : word-address width, 2**ADDR_WIDTH words of 32 bits
//   WAIT_CYCLES : wait states added to each access (0..15)
//
// Ports
//   CLK        in   clock, rising edge
//   Reset      in   synchronous active-high reset (array contents preserved)
//   ReqValid   in   request present
//   ReqReady   out  request can be accepted (IDLE and not in reset)
//   ReqWrite   in   1 = store, 0 = load
//   ReqAddr    in   word address
//   ReqWData   in   store data
//   ReqByteEn  in   per-byte store enables (DMEM_BYTE_EN_EN only)
//   RespValid  out  response present (RESP state)
//   RespReady  in   response accepted
//   RespRData  out  load data, 0 for stores
//   RespWrite  out  captured ReqWrite of the current response
//   Busy       out  FSM is not IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; accept captures the request
// WAIT  | counting down wait states; array access on the leaving edge
// RESP  | response held stable until RespValid & RespReady
// ---------------------------------------------------------------------------
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 6,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic                  ReqWrite,
   input  logic [ADDR_WIDTH-1:0] ReqAddr,
   input  logic [31:0]           ReqWData,
`ifdef DMEM_BYTE_EN_EN
   input  logic [3:0]            ReqByteEn,
`endif
   output logic                  RespValid,
   input  logic                  RespReady,
   output logic [31:0]           RespRData,
   output logic                  RespWrite,
   output logic                  Busy
);

   localparam int         DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [31:0]           r_resp_rdata;
   logic                  r_resp_write;
   logic [31:0]           r_mem [DEPTH];
`ifdef DMEM_BYTE_EN_EN
   logic [3:0]            r_be;
`endif

   // Array access happens on the edge that enters RESP. With zero wait states
   // that is the accept edge itself, so the live request inputs are used;
   // otherwise the captured request is used.
   logic                  w_access;
   logic                  w_acc_write;
   logic [ADDR_WIDTH-1:0] w_acc_addr;
   logic [31:0]           w_acc_wdata;
   logic [3:0]            w_acc_be;
   logic [31:0]           w_mem_rd;

   always_comb begin
      w_access    = 1'b0;
      w_acc_write = r_write;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
`ifdef DMEM_BYTE_EN_EN
      w_acc_be    = r_be;
`else
      w_acc_be    = 4'hF;
`endif
      if (!Reset) begin
         case (r_state)
            S_IDLE: begin
               if (ReqValid && (WAIT_CYCLES == 0)) begin
                  w_access    = 1'b1;
                  w_acc_write = ReqWrite;
                  w_acc_addr  = ReqAddr;
                  w_acc_wdata = ReqWData;
`ifdef DMEM_BYTE_EN_EN
                  w_acc_be    = ReqByteEn;
`endif
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd1) w_access = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign w_mem_rd = r_mem[w_acc_addr];

   // No reset on the array: contents survive Reset. The write strobe is
   // already suppressed while Reset is high, so a reset on the entering edge
   // abandons the store.
   always_ff @(posedge CLK) begin
      if (w_access && w_acc_write) begin
         for (int i = 0; i < 4; i++) begin
            if (w_acc_be[i]) r_mem[w_acc_addr][8*i +: 8] <= w_acc_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 32'd0;
         r_resp_rdata <= 32'd0;
         r_resp_write <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
         r_be         <= 4'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ReqValid) begin
                  r_write <= ReqWrite;
                  r_addr  <= ReqAddr;
                  r_wdata <= ReqWData;
`ifdef DMEM_BYTE_EN_EN
                  r_be    <= ReqByteEn;
`endif
                  r_cnt   <= WAIT_LD;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
            end
            S_RESP: begin
               if (RespReady) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // Entry into RESP overrides the WAIT transition above.
         if (w_access) begin
            r_state      <= S_RESP;
            r_resp_rdata <= w_acc_write ? 32'd0 : w_mem_rd;
            r_resp_write <= w_acc_write;
         end
      end
   end

   assign ReqReady  = (r_state == S_IDLE) && !Reset;
   assign RespValid = (r_state == S_RESP);
   assign Busy      = (r_state != S_IDLE);
   assign RespRData = r_resp_rdata;
   assign RespWrite = r_resp_write;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder. Instance 0 uses WAIT_CYCLES=2,
// instance 1 uses WAIT_CYCLES=0. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        clk;
   logic        rst     [2];
   logic        rv      [2];
   logic        rr      [2];
   logic        rw      [2];
   logic [5:0]  ra      [2];
   logic [31:0] rwd     [2];
   logic [3:0]  rbe     [2];
   logic        sv      [2];
   logic        srdy    [2];
   logic [31:0] srd     [2];
   logic        sw      [2];
   logic        busy    [2];

   int n_checks;
   int n_fail;

   data_mem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(2)) u_dut0 (
      .CLK(clk), .Reset(rst[0]), .ReqValid(rv[0]), .ReqReady(rr[0]),
      .ReqWrite(rw[0]), .ReqAddr(ra[0]), .ReqWData(rwd[0]),
`ifdef DMEM_BYTE_EN_EN
      .ReqByteEn(rbe[0]),
`endif
      .RespValid(sv[0]), .RespReady(srdy[0]), .RespRData(srd[0]),
      .RespWrite(sw[0]), .Busy(busy[0])
   );

   data_mem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(0)) u_dut1 (
      .CLK(clk), .Reset(rst[1]), .ReqValid(rv[1]), .ReqReady(rr[1]),
      .ReqWrite(rw[1]), .ReqAddr(ra[1]), .ReqWData(rwd[1]),
`ifdef DMEM_BYTE_EN_EN
      .ReqByteEn(rbe[1]),
`endif
      .RespValid(sv[1]), .RespReady(srdy[1]), .RespRData(srd[1]),
      .RespWrite(sw[1]), .Busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one request from IDLE, measures cycles from the accept edge to the
   // first RespValid cycle, captures the response, and completes the handshake.
   task automatic access(input int d, input logic wr, input logic [5:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] rd, output logic rwo, output int lat);
      rv[d] = 1'b1; rw[d] = wr; ra[d] = a; rwd[d] = wd; rbe[d] = be; srdy[d] = 1'b1;
      tick;
      rv[d] = 1'b0;
      lat = 1;
      while (!sv[d] && lat < 40) begin
         tick;
         lat++;
      end
      rd  = srd[d];
      rwo = sw[d];
      tick;
   endtask

   task automatic test_reset;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; rv[d] = 1'b0; srdy[d] = 1'b1; rw[d] = 1'b0;
         ra[d] = '0; rwd[d] = '0; rbe[d] = 4'hF;
      end
      tick;
      tick;
      n_checks++; if (rr[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", rr[0]); end
      n_checks++; if (sv[0] !== 1'b0) begin n_fail++; $display("FAIL reset_respvalid: got %b want 0", sv[0]); end
      n_checks++; if (srd[0] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", srd[0]); end
      n_checks++; if (sw[0] !== 1'b0) begin n_fail++; $display("FAIL reset_respwrite: got %b want 0", sw[0]); end
      n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
      n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy[1]); end
      rst[0] = 1'b0; rst[1] = 1'b0;
      #1;
      n_checks++; if (rr[0] !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", rr[0]); end
      n_checks++; if (rr[1] !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after1: got %b want 1", rr[1]); end
   endtask

   task automatic test_store_load;
      logic [31:0] rd; logic rwo; int lat;
      access(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF, rd, rwo, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL store_latency: got %0d want 3", lat); end
      n_checks++; if (rwo !== 1'b1) begin n_fail++; $display("FAIL store_respwrite: got %b want 1", rwo); end
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL store_rdata: got %h want 0", rd); end
      n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL store_idle_after: busy %b want 0", busy[0]); end
      access(0, 1'b0, 6'd5, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency: got %0d want 3", lat); end
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
      n_checks++; if (rwo !== 1'b0) begin n_fail++; $display("FAIL load_respwrite: got %b want 0", rwo); end
   endtask

   task automatic test_addr_range;
      logic [31:0] rd; logic rwo; int lat;
      access(0, 1'b1, 6'd0,  32'hA0A0_0000, 4'hF, rd, rwo, lat);
      access(0, 1'b1, 6'd63, 32'hA0A0_003F, 4'hF, rd, rwo, lat);
      access(0, 1'b1, 6'd31, 32'hA0A0_001F, 4'hF, rd, rwo, lat);
      access(0, 1'b1, 6'd32, 32'hA0A0_0020, 4'hF, rd, rwo, lat);
      access(0, 1'b0, 6'd0, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'hA0A0_0000) begin n_fail++; $display("FAIL addr0: got %h want a0a00000", rd); end
      access(0, 1'b0, 6'd63, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'hA0A0_003F) begin n_fail++; $display("FAIL addr63: got %h want a0a0003f", rd); end
      access(0, 1'b0, 6'd31, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'hA0A0_001F) begin n_fail++; $display("FAIL addr31: got %h want a0a0001f", rd); end
      access(0, 1'b0, 6'd32, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'hA0A0_0020) begin n_fail++; $display("FAIL addr32: got %h want a0a00020", rd); end
   endtask

   task automatic test_backpressure;
      int lat;
      rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 6'd5; srdy[0] = 1'b0;
      tick;
      rv[0] = 1'b0;
      lat = 1;
      while (!sv[0] && lat < 40) begin tick; lat++; end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d want 3", lat); end
      // Offer a competing request while stalled; it must not be taken.
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 6'd5; rwd[0] = 32'h0BAD0BAD;
      for (int i = 0; i < 4; i++) begin
         tick;
         n_checks++; if (sv[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: cycle %0d got %b want 1", i, sv[0]); end
         n_checks++; if (srd[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_rdata_hold: cycle %0d got %h want deadbeef", i, srd[0]); end
         n_checks++; if (rr[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: cycle %0d got %b want 0", i, rr[0]); end
      end
      rv[0] = 1'b0;
      srdy[0] = 1'b1;
      tick;
      n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_idle: busy %b want 0", busy[0]); end
      n_checks++; if (rr[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", rr[0]); end
      n_checks++; if (sv[0] !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", sv[0]); end
   endtask

   task automatic test_reset_in_wait;
      logic [31:0] rd; logic rwo; int lat;
      access(0, 1'b1, 6'd9, 32'h00000001, 4'hF, rd, rwo, lat);
      access(0, 1'b0, 6'd9, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'h00000001) begin n_fail++; $display("FAIL rw_preload: got %h want 00000001", rd); end
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 6'd9; rwd[0] = 32'hFFFFFFFF;
      tick;
      rv[0] = 1'b0;
      tick;
      // Counter is at 1 here: the coming edge would perform the store.
      rst[0] = 1'b1;
      tick;
      n_checks++; if (sv[0] !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %b want 0", sv[0]); end
      n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rw_busy: got %b want 0", busy[0]); end
      n_checks++; if (srd[0] !== 32'd0) begin n_fail++; $display("FAIL rw_rdata: got %h want 0", srd[0]); end
      n_checks++; if (sw[0] !== 1'b0) begin n_fail++; $display("FAIL rw_respwrite: got %b want 0", sw[0]); end
      n_checks++; if (rr[0] !== 1'b0) begin n_fail++; $display("FAIL rw_ready_in_reset: got %b want 0", rr[0]); end
      rst[0] = 1'b0;
      #1;
      n_checks++; if (rr[0] !== 1'b1) begin n_fail++; $display("FAIL rw_ready_after: got %b want 1", rr[0]); end
      access(0, 1'b0, 6'd9, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'h00000001) begin n_fail++; $display("FAIL rw_abandoned: got %h want 00000001", rd); end
   endtask

   task automatic test_reset_in_resp;
      logic [31:0] rd; logic rwo; int lat;
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 6'd10; rwd[0] = 32'hCAFEF00D; srdy[0] = 1'b0;
      tick;
      rv[0] = 1'b0;
      lat = 1;
      while (!sv[0] && lat < 40) begin tick; lat++; end
      n_checks++; if (sv[0] !== 1'b1) begin n_fail++; $display("FAIL rr_reach_resp: got %b want 1", sv[0]); end
      rst[0] = 1'b1;
      tick;
      rst[0] = 1'b0;
      srdy[0] = 1'b1;
      n_checks++; if (sv[0] !== 1'b0) begin n_fail++; $display("FAIL rr_dropped: got %b want 0", sv[0]); end
      tick;
      access(0, 1'b0, 6'd10, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rr_store_kept: got %h want cafef00d", rd); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd; logic rwo; int lat; int last; int n_acc; int guard;
      access(0, 1'b1, 6'd21, 32'h21212121, 4'hF, rd, rwo, lat);
      last = -1; n_acc = 0;
      rv[0] = 1'b1; srdy[0] = 1'b1;
      for (int c = 0; c < 14; c++) begin
         n_checks++; if (rr[0] !== !busy[0]) begin n_fail++; $display("FAIL b2b_ready_vs_busy: cycle %0d ready %b busy %b", c, rr[0], busy[0]); end
         if (rr[0]) begin
            rw[0] = 1'b1; ra[0] = 6'd20; rwd[0] = 32'h0A0A0A0A;
            if (last >= 0) begin
               n_checks++; if (c - last < 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want >=4", c - last); end
            end
            last = c;
            n_acc++;
         end else begin
            // Garbage while busy; must be ignored.
            rw[0] = 1'b1; ra[0] = 6'd21; rwd[0] = 32'hBBBBBBBB;
         end
         tick;
      end
      rv[0] = 1'b0;
      n_checks++; if (n_acc !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", n_acc); end
      guard = 0;
      while (busy[0] && guard < 40) begin tick; guard++; end
      n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: busy %b want 0", busy[0]); end
      access(0, 1'b0, 6'd20, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'h0A0A0A0A) begin n_fail++; $display("FAIL b2b_addr20: got %h want 0a0a0a0a", rd); end
      access(0, 1'b0, 6'd21, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'h21212121) begin n_fail++; $display("FAIL b2b_addr21: got %h want 21212121", rd); end
   endtask

   task automatic test_wait0;
      logic [31:0] rd; logic rwo; int lat;
      access(1, 1'b1, 6'd63, 32'h12345678, 4'hF, rd, rwo, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL w0_store_latency: got %0d want 1", lat); end
      n_checks++; if (rwo !== 1'b1) begin n_fail++; $display("FAIL w0_store_respwrite: got %b want 1", rwo); end
      access(1, 1'b0, 6'd63, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL w0_load_latency: got %0d want 1", lat); end
      n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL w0_load_rdata: got %h want 12345678", rd); end
      n_checks++; if (rwo !== 1'b0) begin n_fail++; $display("FAIL w0_load_respwrite: got %b want 0", rwo); end
   endtask

`ifdef DMEM_BYTE_EN_EN
   task automatic test_byte_en;
      logic [31:0] rd; logic rwo; int lat;
      access(0, 1'b1, 6'd2, 32'h11223344, 4'hF, rd, rwo, lat);
      access(0, 1'b1, 6'd2, 32'hAABBCCDD, 4'b0101, rd, rwo, lat);
      access(0, 1'b0, 6'd2, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_0101: got %h want 11bb33dd", rd); end
      access(0, 1'b1, 6'd2, 32'hFFFFFFFF, 4'b0000, rd, rwo, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL be_0000_latency: got %0d want 3", lat); end
      access(0, 1'b0, 6'd2, 32'h0, 4'hF, rd, rwo, lat);
      n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_0000: got %h want 11bb33dd", rd); end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_store_load;
      test_addr_range;
      test_backpressure;
      test_reset_in_wait;
      test_reset_in_resp;
      test_back_to_back;
      test_wait0;
`ifdef DMEM_BYTE_EN_EN
      test_byte_en;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
